// File: rtl/spi_cmd_decoder.sv
// Decodes 3-byte SPI transactions into typed commands and queues them (depth 4 with SPI_CMD_FIFO_EN, else 1).
// Latency: cmd_valid rises 3 clk after the synchronised chip select falls (when the buffer is empty).
// Backpressure: the head holds while cmd_ready is low; a push into a full buffer is dropped and flagged in err_overflow.
module spi_cmd_decoder (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cs,
    input  logic [7:0] command,
    input  logic [7:0] databyte1,
    input  logic [7:0] databyte2,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [1:0] cmd_type,
    output logic [7:0] cmd_arg0,
    output logic [7:0] cmd_arg1,
    output logic       err_unknown,
    output logic       err_overflow,
    input  logic       err_clear
);

`ifdef SPI_CMD_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif
    // Pointers keep at least one bit; with depth 1 they simply stay at zero.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SLOTS = 1 << PTR_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACTIVE  = 2'd1;
    localparam logic [1:0] SETTLE  = 2'd2;
    localparam logic [1:0] CAPTURE = 2'd3;

    typedef struct packed {
        logic [1:0] typ;
        logic [7:0] arg0;
        logic [7:0] arg1;
    } cmd_t;

    logic             cs_meta;
    logic             cs_s;
    logic [1:0]       state;
    logic             dec_known;
    cmd_t             dec_dat;
    logic             in_capture;
    logic             push;
    logic             pop;
    logic             full;
    logic             push_ok;
    logic             unknown_evt;
    logic             overflow_evt;
    cmd_t             mem [0:SLOTS-1];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    cmd_t             head;

    // Two-flop synchroniser for the chip select; the data bytes are quasi-static by the time they are sampled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_meta <= 1'b0;
            cs_s    <= 1'b0;
        end else begin
            cs_meta <= cs;
            cs_s    <= cs_meta;
        end
    end

    // Transaction tracker: one settle cycle after cs drops, then a single capture cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (cs_s)  state <= ACTIVE;
                ACTIVE:  if (!cs_s) state <= SETTLE;
                SETTLE:  state <= CAPTURE;
                default: state <= IDLE;
            endcase
        end
    end

    // Opcode decode of the raw bytes; only meaningful during CAPTURE.
    always_comb begin
        dec_known = 1'b0;
        dec_dat   = '0;
        case (command)
            8'h01: begin
                dec_known    = 1'b1;
                dec_dat.typ  = 2'b00;
                dec_dat.arg0 = {6'b0, databyte1[1:0]};
            end
            8'h02: begin
                dec_known    = 1'b1;
                dec_dat.typ  = 2'b01;
                dec_dat.arg0 = databyte1;
                dec_dat.arg1 = databyte2;
            end
            8'h03: begin
                dec_known    = 1'b1;
                dec_dat.typ  = 2'b10;
            end
            8'h04: begin
                dec_known    = 1'b1;
                dec_dat.typ  = 2'b11;
                dec_dat.arg0 = databyte1;
            end
            default: dec_known = 1'b0;
        endcase
    end

    assign in_capture   = (state == CAPTURE);
    assign push         = in_capture && dec_known;
    assign unknown_evt  = in_capture && !dec_known;
    assign pop          = cmd_valid && cmd_ready;
    assign full         = (count == FULL_CNT);
    // A full buffer still accepts a push when the head leaves on the same edge.
    assign push_ok      = push && (!full || pop);
    assign overflow_evt = push && full && !pop;

    // Circular command buffer with wrap-around pointers and an occupancy counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SLOTS; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= dec_dat;
                wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; a new event wins over a coincident clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_unknown  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (unknown_evt)      err_unknown <= 1'b1;
            else if (err_clear)   err_unknown <= 1'b0;
            if (overflow_evt)     err_overflow <= 1'b1;
            else if (err_clear)   err_overflow <= 1'b0;
        end
    end

    assign head      = mem[rd_ptr];
    assign cmd_valid = (count != '0);
    assign cmd_type  = head.typ;
    assign cmd_arg0  = head.arg0;
    assign cmd_arg1  = head.arg1;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed self-checking bench for spi_cmd_decoder (default and SPI_CMD_FIFO_EN builds).
// Inputs change on falling clk edges, outputs are sampled on falling edges.
// All expected values are hand-computed constants.
module tb_spi_cmd_decoder;

`ifdef SPI_CMD_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cs;
    logic [7:0] command;
    logic [7:0] databyte1;
    logic [7:0] databyte2;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [1:0] cmd_type;
    logic [7:0] cmd_arg0;
    logic [7:0] cmd_arg1;
    logic       err_unknown;
    logic       err_overflow;
    logic       err_clear;

    int n_checks = 0;
    int n_errors = 0;

    spi_cmd_decoder dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cs           (cs),
        .command      (command),
        .databyte1    (databyte1),
        .databyte2    (databyte2),
        .cmd_ready    (cmd_ready),
        .cmd_valid    (cmd_valid),
        .cmd_type     (cmd_type),
        .cmd_arg0     (cmd_arg0),
        .cmd_arg1     (cmd_arg1),
        .err_unknown  (err_unknown),
        .err_overflow (err_overflow),
        .err_clear    (err_clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Raise cs with the given bytes, hold it, and drop it; returns on the negedge where cs fell.
    task automatic cs_txn(input logic [7:0] c, input logic [7:0] b1, input logic [7:0] b2);
        command   = c;
        databyte1 = b1;
        databyte2 = b2;
        cs        = 1'b1;
        repeat (4) @(negedge clk);
        cs = 1'b0;
    endtask

    // Full transaction including the decode pipeline (returns one cycle after the push edge).
    task automatic send(input logic [7:0] c, input logic [7:0] b1, input logic [7:0] b2);
        cs_txn(c, b1, b2);
        repeat (5) @(negedge clk);
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
    endtask

    initial begin
        int pops;
        logic [1:0] last_type;
        logic [7:0] last_arg0;

        reset_n   = 1'b0;
        cs        = 1'b0;
        command   = 8'h00;
        databyte1 = 8'h00;
        databyte2 = 8'h00;
        cmd_ready = 1'b1;
        err_clear = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", cmd_valid, 0);
        check("rst_type", cmd_type, 0);
        check("rst_arg0", cmd_arg0, 0);
        check("rst_arg1", cmd_arg1, 0);
        check("rst_err_unknown", err_unknown, 0);
        check("rst_err_overflow", err_overflow, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // PLACE_FOOD with latency: valid exactly one cycle, 5 negedges after cs drops
        cs_txn(8'h02, 8'h18, 8'h09);
        repeat (4) @(negedge clk);
        check("lat_early_valid", cmd_valid, 0);
        @(negedge clk);
        check("lat_valid", cmd_valid, 1);
        check("food_type", cmd_type, 2'b01);
        check("food_arg0", cmd_arg0, 8'h18);
        check("food_arg1", cmd_arg1, 8'h09);
        @(negedge clk);
        check("food_single_pulse", cmd_valid, 0);
        check("food_no_err", err_unknown, 0);

        // Unknown opcode: flag set, nothing pushed, clear works
        send(8'h07, 8'hAA, 8'h55);
        check("unk_no_valid", cmd_valid, 0);
        check("unk_flag", err_unknown, 1);
        repeat (3) @(negedge clk);
        check("unk_sticky", err_unknown, 1);
        pulse_clear();
        check("unk_cleared", err_unknown, 0);

        // Clear coinciding with the error edge: flag ends set
        cs_txn(8'hFF, 8'h00, 8'h00);
        repeat (4) @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("unk_clear_collide", err_unknown, 1);
        pulse_clear();
        check("unk_cleared2", err_unknown, 0);

        // SET_DIR masks databyte1 to two bits and holds under backpressure
        cmd_ready = 1'b0;
        send(8'h01, 8'hFE, 8'h77);
        check("dir_valid", cmd_valid, 1);
        check("dir_type", cmd_type, 2'b00);
        check("dir_arg0", cmd_arg0, 8'h02);
        check("dir_arg1", cmd_arg1, 8'h00);
        repeat (3) @(negedge clk);
        check("dir_hold_valid", cmd_valid, 1);
        check("dir_hold_arg0", cmd_arg0, 8'h02);
        cmd_ready = 1'b1;
        @(negedge clk);
        check("dir_popped", cmd_valid, 0);

        // cs glitch that never reaches a sampling edge produces nothing
        cmd_ready = 1'b0;
        command   = 8'h03;
        cs        = 1'b1;
        #2;
        cs        = 1'b0;
        repeat (8) @(negedge clk);
        check("glitch_no_push", cmd_valid, 0);

        // Fill past capacity: overflow flagged, head intact
        for (int i = 0; i <= DEPTH; i++) send(8'h01, 8'h03, 8'h00);
        check("ovf_valid", cmd_valid, 1);
        check("ovf_arg0", cmd_arg0, 8'h03);
        check("ovf_flag", err_overflow, 1);
        pulse_clear();
        check("ovf_cleared", err_overflow, 0);

        // Push into a full buffer on the same edge as a pop: accepted, no overflow
        cs_txn(8'h04, 8'h21, 8'h00);
        repeat (4) @(negedge clk);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        check("pushpop_no_ovf", err_overflow, 0);
        check("pushpop_valid", cmd_valid, 1);

        // Drain: exactly DEPTH entries, newest (SET_SPEED 0x21) last
        cmd_ready = 1'b1;
        pops      = 0;
        last_type = 2'b00;
        last_arg0 = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (cmd_valid) begin
                pops++;
                last_type = cmd_type;
                last_arg0 = cmd_arg0;
            end
            @(negedge clk);
        end
        check("drain_pops", pops, DEPTH);
        check("drain_last_type", last_type, 2'b11);
        check("drain_last_arg0", last_arg0, 8'h21);

        // Ordering under backpressure: SET_SPEED then RESTART
        cmd_ready = 1'b0;
        send(8'h04, 8'h10, 8'h00);
        send(8'h03, 8'h00, 8'h00);
        check("order_first_type", cmd_type, 2'b11);
        check("order_first_arg0", cmd_arg0, 8'h10);
        cmd_ready = 1'b1;
        @(negedge clk);
`ifdef SPI_CMD_FIFO_EN
        check("order_second_valid", cmd_valid, 1);
        check("order_second_type", cmd_type, 2'b10);
        check("order_second_ovf", err_overflow, 0);
`else
        check("order_second_dropped", cmd_valid, 0);
        check("order_second_ovf", err_overflow, 1);
`endif
        repeat (2) @(negedge clk);
        check("order_empty", cmd_valid, 0);
        pulse_clear();

        // Reset mid-transaction with entries buffered: only the in-flight command survives
        cmd_ready = 1'b0;
        send(8'h02, 8'h01, 8'h02);
        send(8'h02, 8'h03, 8'h04);
        command   = 8'h04;
        databyte1 = 8'h55;
        databyte2 = 8'h00;
        cs        = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_mid_valid", cmd_valid, 0);
        check("rst_mid_ovf", err_overflow, 0);
        check("rst_mid_type", cmd_type, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        cs = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_inflight_valid", cmd_valid, 1);
        check("rst_inflight_type", cmd_type, 2'b11);
        check("rst_inflight_arg0", cmd_arg0, 8'h55);
        cmd_ready = 1'b1;
        @(negedge clk);
        check("rst_only_one", cmd_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_cmd_decoder.md
SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

Interface
REQ-001 The module SHALL have port: clk  input  1  system clock; all state on its rising edge.
REQ-002 The module SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-003 The module SHALL have port: cs  input  1  raw SPI chip select from the receiver, asynchronous to clk, active high during a transaction.
REQ-004 The module SHALL have ports: command, databyte1, databyte2  input  8 each  raw shift-register bytes from the SPI receiver, quasi-static once cs is low.
REQ-005 The module SHALL have port: cmd_ready  input  1  consumer accepts the head entry when high with cmd_valid.
REQ-006 The module SHALL have port: cmd_valid  output  1  a decoded entry is at the head.
REQ-007 The module SHALL have port: cmd_type  output  2  00 SET_DIR, 01 PLACE_FOOD, 10 RESTART, 11 SET_SPEED.
REQ-008 The module SHALL have ports: cmd_arg0, cmd_arg1  output  8 each  head-entry arguments.
REQ-009 The module SHALL have port: err_unknown  output  1  sticky: a transaction carried an undefined opcode.
REQ-010 The module SHALL have port: err_overflow  output  1  sticky: a valid command was dropped because the buffer was full.
REQ-011 The module SHALL have port: err_clear  input  1  synchronous clear of both sticky flags.

Function
REQ-012 The module SHALL synchronise cs through a 2-flop synchroniser (cs_s) before any use; the data bytes are not synchronised.
REQ-013 The FSM SHALL have states IDLE, ACTIVE, SETTLE, CAPTURE: IDLE->ACTIVE on cs_s=1; ACTIVE->SETTLE on cs_s=0; SETTLE->CAPTURE unconditionally after one cycle; CAPTURE->IDLE after one cycle.
REQ-014 In CAPTURE the module SHALL sample all three bytes and decode the command byte: 0x01->SET_DIR, arg0={6'b0,databyte1[1:0]}, arg1=0; 0x02->PLACE_FOOD, arg0=databyte1, arg1=databyte2; 0x03->RESTART, args 0; 0x04->SET_SPEED, arg0=databyte1, arg1=0.
REQ-015 Any other opcode SHALL set err_unknown in the cycle after CAPTURE and SHALL NOT be pushed.
REQ-016 A valid decode SHALL be pushed in CAPTURE; cmd_valid SHALL go high the next cycle when the buffer was empty (latency cs_s fall -> cmd_valid = 3 clk).
REQ-017 The buffer SHALL be FIFO-ordered; an entry is popped on a clk edge where cmd_valid and cmd_ready are both high; outputs SHALL hold stable while cmd_valid=1 and cmd_ready=0.
REQ-018 A push into a full buffer SHALL be discarded and set err_overflow; a simultaneous pop and push when full SHALL succeed with no overflow.
REQ-019 A cs pulse shorter than the synchroniser resolution (never seen as cs_s=1) SHALL produce no push.
REQ-020 err_clear SHALL clear both sticky flags; if an error event and err_clear coincide, the flag SHALL end set.
REQ-021 Read/write pointers SHALL wrap modulo buffer depth; occupancy is tracked by a counter of width log2(depth)+1.

Reset
REQ-022 While reset_n=0: FSM=IDLE, synchroniser flops=0, buffer empty, cmd_valid=0, cmd_type=0, cmd_arg0=0, cmd_arg1=0, err_unknown=0, err_overflow=0.
REQ-023 Reset asserted mid-transaction SHALL discard any partial or buffered commands; after release, a cs already high SHALL be treated as a new transaction (IDLE->ACTIVE) and its end decoded normally.

Configuration
REQ-024 With macro SPI_CMD_FIFO_EN defined, the buffer SHALL be a 4-entry FIFO.
REQ-025 Without SPI_CMD_FIFO_EN, the buffer SHALL be a single holding register (depth 1) with identical handshake, overflow and reset behaviour.

Verification
REQ-026 Scenario: transaction {0x02,0x18,0x09}, cmd_ready=1 -> one cmd_valid pulse, cmd_type=01, arg0=0x18, arg1=0x09, 3 clk after cs_s falls.
REQ-027 Scenario: transaction {0x07,0xAA,0x55} -> no cmd_valid, err_unknown=1 until err_clear pulse, then 0.
REQ-028 Scenario: cmd_ready=0, five transactions {0x01,0x03,x} (FIFO_EN) -> four entries held, arg0=0x03, err_overflow=1; raise cmd_ready -> exactly four pops in order.
REQ-029 Scenario: cmd_ready held 0 over {0x04,0x10,0}, {0x03,0,0} -> SET_SPEED with arg0=0x10 popped first, then RESTART.
REQ-030 Scenario: reset_n pulsed low with cs high and two entries buffered -> cmd_valid=0 immediately; after cs falls, only the in-flight transaction is delivered.
REQ-031 Scenario: without SPI_CMD_FIFO_EN, cmd_ready=0, two valid transactions -> first held, second dropped, err_overflow=1.
